cle_param: RTL and testbench

Parametrised two-pass connected-component labeling engine, the successor to the fixed 32x32, 4-connectivity labeler. It reads a binary image from a packed ROM, labels foreground pixels under run-time-selectable 4- or 8-connectivity, and resolves equivalences through an internal union-find table. It writes compact, consecutively numbered component labels (1..N, ordered by each component's first pixel in raster order) to the external label SRAM. It adds a start/busy/done handshake, a component count and label-overflow detection.

---
 rtl/cle_param_if.sv | 32 +++
 rtl/cle_param.sv | 341 ++++++++++++++++++++++++++++++++++
 tb/tb_cle_param.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/cle_param_if.sv
// rtl/cle_param_if.sv - control, ROM and label-SRAM signals of the labeling engine
interface cle_param_if #(
  parameter int IMG_W   = 32,
  parameter int IMG_H   = 32,
  parameter int ROM_DW  = 8,
  parameter int LABEL_W = 8
);
  localparam int ROM_AW = $clog2(IMG_W * IMG_H / ROM_DW);
  localparam int PIX_AW = $clog2(IMG_W * IMG_H);

  logic               start;
  logic               conn8;
  logic [ROM_AW-1:0]  rom_a;
  logic [ROM_DW-1:0]  rom_q;
  logic [PIX_AW-1:0]  sram_a;
  logic [LABEL_W-1:0] sram_d;
  logic               sram_wen;
  logic               busy;
  logic               done;
  logic [LABEL_W-1:0] num_labels;
  logic               overflow;

  modport slave (
    input  start, conn8, rom_q,
    output rom_a, sram_a, sram_d, sram_wen, busy, done, num_labels, overflow
  );

  modport master (
    output start, conn8, rom_q,
    input  rom_a, sram_a, sram_d, sram_wen, busy, done, num_labels, overflow
  );
endinterface

// File: rtl/cle_param.sv
// rtl/cle_param.sv - two-pass connected-component labeler with union-find table
// Pass 1 assigns provisional labels and merges them; RESOLVE compacts roots; pass 2 writes final labels.
module cle_param #(
  parameter int IMG_W   = 32,
  parameter int IMG_H   = 32,
  parameter int ROM_DW  = 8,
  parameter int LABEL_W = 8
) (
  input logic      clk,
  input logic      reset,
  cle_param_if.slave bus
);
  localparam int ROM_AW = $clog2(IMG_W * IMG_H / ROM_DW);
  localparam int PIX_AW = $clog2(IMG_W * IMG_H);
  localparam int COL_W  = $clog2(IMG_W);
  localparam int SUB_W  = $clog2(ROM_DW);
  localparam int TBL_N  = 1 << LABEL_W;

  localparam logic [LABEL_W-1:0] LBL_ONE  = 1;
  localparam logic [LABEL_W-1:0] LBL_MAX  = '1;
  localparam logic [PIX_AW-1:0]  PIX_ONE  = 1;
  localparam logic [PIX_AW-1:0]  PIX_LAST = '1;
  localparam logic [COL_W-1:0]   COL_ONE  = 1;
  localparam logic [COL_W-1:0]   COL_LAST = '1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INIT    = 3'd1;
  localparam logic [2:0] S_PASS1   = 3'd2;
  localparam logic [2:0] S_UNION   = 3'd3;
  localparam logic [2:0] S_RESOLVE = 3'd4;
  localparam logic [2:0] S_PASS2   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [2:0] ST_LOAD = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_EVAL = 3'd2;
  localparam logic [2:0] ST_LK   = 3'd3;
  localparam logic [2:0] ST_END  = 3'd4;
  localparam logic [2:0] U_RA    = 3'd0;
  localparam logic [2:0] U_FA    = 3'd1;
  localparam logic [2:0] U_RB    = 3'd2;
  localparam logic [2:0] U_FB    = 3'd3;
  localparam logic [2:0] U_WR    = 3'd4;
  localparam logic [2:0] R_RD    = 3'd0;
  localparam logic [2:0] R_CHK   = 3'd1;
  localparam logic [2:0] R_P2    = 3'd2;

  logic [2:0]         state, step;
  logic               c8;
  logic [PIX_AW-1:0]  pix;
  logic [LABEL_W-1:0] next_label, left_lbl, m_reg, xa, xb, idx, cnt;
  logic [LABEL_W-1:0] nbv [4];
  logic [3:0]         mask;
  logic [ROM_AW-1:0]  rom_a_r;
  logic [PIX_AW-1:0]  sram_a_r;
  logic [LABEL_W-1:0] sram_d_r, num_labels_r;
  logic               sram_wen_r, overflow_r;

  logic [LABEL_W-1:0] lb [IMG_W];
  logic [LABEL_W-1:0] parent [TBL_N];
  logic               tbl_we;
  logic [LABEL_W-1:0] tbl_addr, tbl_wd, tbl_q;

  logic [COL_W-1:0]   col;
  logic               row0;
  logic [ROM_DW-1:0]  rom_sh;
  logic               fg, new_lbl;
  logic [LABEL_W-1:0] nb [4];
  logic [LABEL_W-1:0] nb_min, raw;
  logic [3:0]         pend;
  logic [PIX_AW-1:0]  pix_inc;
  logic [2:0]         step_inc, step_here;

  function automatic logic [1:0] first1(input logic [3:0] v);
    first1 = 2'd3;
    for (int k = 3; k >= 0; k--)
      if (v[k]) first1 = k[1:0];
  endfunction

  assign bus.rom_a      = rom_a_r;
  assign bus.sram_a     = sram_a_r;
  assign bus.sram_d     = sram_d_r;
  assign bus.sram_wen   = sram_wen_r;
  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = (state == S_DONE);
  assign bus.num_labels = num_labels_r;
  assign bus.overflow   = overflow_r;

  // Neighbour gathering and provisional label, shared by both passes so pass 2 reproduces pass 1.
  always_comb begin
    col    = pix[COL_W-1:0];
    row0   = (pix[PIX_AW-1:COL_W] == '0);
    rom_sh = bus.rom_q << pix[SUB_W-1:0];
    fg     = rom_sh[ROM_DW-1];
    nb[0]  = (col != '0) ? left_lbl : '0;
    nb[1]  = (c8 && !row0 && col != '0) ? lb[col - COL_ONE] : '0;
    nb[2]  = (!row0) ? lb[col] : '0;
    nb[3]  = (c8 && !row0 && col != COL_LAST) ? lb[col + COL_ONE] : '0;
    nb_min = '0;
    for (int k = 0; k < 4; k++)
      if (nb[k] != '0 && (nb_min == '0 || nb[k] < nb_min)) nb_min = nb[k];
    new_lbl = fg && (nb_min == '0);
    raw     = !fg ? '0 : (new_lbl ? next_label : nb_min);
    pend    = '0;
    for (int k = 0; k < 4; k++) begin
      pend[k] = fg && nb[k] != '0 && nb[k] != nb_min;
      for (int j = 0; j < k; j++)
        if (nb[j] == nb[k]) pend[k] = 1'b0;
    end
    pix_inc   = pix + PIX_ONE;
    // rom_q stays valid while the word address is unchanged, so only word boundaries reload.
    step_inc  = (pix_inc[SUB_W-1:0] == '0) ? ST_LOAD : ST_EVAL;
    step_here = (pix[SUB_W-1:0] == '0) ? ST_LOAD : ST_EVAL;
  end

  // Single table port: at most one read or write per cycle.
  always_comb begin
    tbl_we   = 1'b0;
    tbl_addr = '0;
    tbl_wd   = '0;
    case (state)
      S_INIT: begin
        tbl_we   = 1'b1;
        tbl_addr = idx;
        tbl_wd   = idx;
      end
      S_UNION: begin
        case (step)
          U_RA: tbl_addr = xa;
          U_RB: tbl_addr = xb;
          U_WR: begin
            tbl_we   = (xa != xb);
            tbl_addr = (xa > xb) ? xa : xb;
            tbl_wd   = (xa > xb) ? xb : xa;
          end
          default: ;
        endcase
      end
      S_RESOLVE: begin
        case (step)
          R_RD: tbl_addr = idx;
          R_CHK: begin
            if (tbl_q == idx) begin
              tbl_we   = 1'b1;
              tbl_addr = idx;
              tbl_wd   = cnt + LBL_ONE;
            end else begin
              tbl_addr = tbl_q;
            end
          end
          R_P2: begin
            tbl_we   = 1'b1;
            tbl_addr = idx;
            tbl_wd   = tbl_q;
          end
          default: ;
        endcase
      end
      S_PASS2: if (step == ST_EVAL && fg) tbl_addr = raw;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tbl_we) parent[tbl_addr] <= tbl_wd;
    tbl_q <= parent[tbl_addr];
  end

  // lb[col-1] is written one pixel late so the NW neighbour still sees the previous row.
  always_ff @(posedge clk) begin
    if ((state == S_PASS1 || state == S_PASS2) && step == ST_EVAL) begin
      if (col != '0) lb[col - COL_ONE] <= left_lbl;
      if (col == COL_LAST) lb[col] <= raw;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      step         <= ST_LOAD;
      c8           <= 1'b0;
      pix          <= '0;
      next_label   <= LBL_ONE;
      left_lbl     <= '0;
      m_reg        <= '0;
      xa           <= '0;
      xb           <= '0;
      idx          <= '0;
      cnt          <= '0;
      mask         <= '0;
      for (int k = 0; k < 4; k++) nbv[k] <= '0;
      rom_a_r      <= '0;
      sram_a_r     <= '0;
      sram_d_r     <= '0;
      sram_wen_r   <= 1'b1;
      num_labels_r <= '0;
      overflow_r   <= 1'b0;
    end else begin
      sram_wen_r <= 1'b1;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            c8           <= bus.conn8;
            num_labels_r <= '0;
            overflow_r   <= 1'b0;
            idx          <= '0;
            state        <= S_INIT;
          end
        end
        S_INIT: begin
          idx <= idx + LBL_ONE;
          if (idx == LBL_MAX) begin
            next_label <= LBL_ONE;
            pix        <= '0;
            step       <= ST_LOAD;
            state      <= S_PASS1;
          end
        end
        S_PASS1, S_PASS2: begin
          case (step)
            ST_LOAD: begin
              rom_a_r <= pix[PIX_AW-1:SUB_W];
              step    <= ST_WAIT;
            end
            ST_WAIT: step <= ST_EVAL;
            ST_EVAL: begin
              if (state == S_PASS1 && new_lbl && next_label == LBL_MAX) begin
                overflow_r   <= 1'b1;
                num_labels_r <= '0;
                state        <= S_DONE;
              end else begin
                if (new_lbl) next_label <= next_label + LBL_ONE;
                left_lbl <= raw;
                if (state == S_PASS1) begin
                  pix <= pix_inc;
                  if (pend != '0) begin
                    m_reg <= nb_min;
                    nbv   <= nb;
                    xa    <= nb_min;
                    xb    <= nb[first1(pend)];
                    mask  <= pend & ~(4'b0001 << first1(pend));
                    step  <= U_RA;
                    state <= S_UNION;
                  end else if (pix == PIX_LAST) begin
                    idx   <= LBL_ONE;
                    cnt   <= '0;
                    step  <= R_RD;
                    state <= S_RESOLVE;
                  end else begin
                    step <= step_inc;
                  end
                end else if (fg) begin
                  step <= ST_LK;
                end else begin
                  sram_wen_r <= 1'b0;
                  sram_a_r   <= pix;
                  sram_d_r   <= '0;
                  pix        <= pix_inc;
                  step       <= (pix == PIX_LAST) ? ST_END : step_inc;
                end
              end
            end
            ST_LK: begin
              sram_wen_r <= 1'b0;
              sram_a_r   <= pix;
              sram_d_r   <= tbl_q;
              pix        <= pix_inc;
              step       <= (pix == PIX_LAST) ? ST_END : step_inc;
            end
            default: state <= S_DONE;
          endcase
        end
        S_UNION: begin
          case (step)
            U_RA: step <= U_FA;
            U_FA: begin
              if (tbl_q == xa) step <= U_RB;
              else begin
                xa   <= tbl_q;
                step <= U_RA;
              end
            end
            U_RB: step <= U_FB;
            U_FB: begin
              if (tbl_q == xb) step <= U_WR;
              else begin
                xb   <= tbl_q;
                step <= U_RB;
              end
            end
            default: begin
              if (mask != '0) begin
                xa   <= m_reg;
                xb   <= nbv[first1(mask)];
                mask <= mask & ~(4'b0001 << first1(mask));
                step <= U_RA;
              end else if (pix == '0) begin
                idx   <= LBL_ONE;
                cnt   <= '0;
                step  <= R_RD;
                state <= S_RESOLVE;
              end else begin
                step  <= step_here;
                state <= S_PASS1;
              end
            end
          endcase
        end
        S_RESOLVE: begin
          case (step)
            R_RD: begin
              if (idx == next_label) begin
                num_labels_r <= cnt;
                next_label   <= LBL_ONE;
                pix          <= '0;
                step         <= ST_LOAD;
                state        <= S_PASS2;
              end else begin
                step <= R_CHK;
              end
            end
            R_CHK: begin
              if (tbl_q == idx) begin
                cnt  <= cnt + LBL_ONE;
                idx  <= idx + LBL_ONE;
                step <= R_RD;
              end else begin
                step <= R_P2;
              end
            end
            default: begin
              idx  <= idx + LBL_ONE;
              step <= R_RD;
            end
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cle_param.sv
// tb/tb_cle_param.sv - directed vector bench for cle_param
module tb_cle_param;
  localparam int NPIX    = 1024;
  localparam int LAT_MAX = 256 + 8 * NPIX + 2 * 256 + 8 * NPIX;

  typedef struct {
    int img;
    bit c8;
    int nlab;
    bit ovf;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cle_param_if bus ();
  cle_param dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0] rom [128];
  bit         img [NPIX];
  int         exp_lbl [NPIX];
  int         checks = 0;
  int         failures = 0;
  int         wr_cnt, addr_err, data_err, done_cnt;
  bit         mon_clr = 1'b0;
  vec_t       vecs [12];

  always @(posedge clk) bus.rom_q <= rom[bus.rom_a];

  always @(negedge clk) begin
    if (mon_clr) begin
      wr_cnt = 0; addr_err = 0; data_err = 0; done_cnt = 0;
    end else begin
      if (!bus.sram_wen) begin
        if (int'(bus.sram_a) != wr_cnt) addr_err++;
        if (int'(bus.sram_d) != exp_lbl[bus.sram_a]) data_err++;
        wr_cnt++;
      end
      if (bus.done) done_cnt++;
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic set_px(input int r, input int c, input int l);
    img[r * 32 + c] = 1'b1;
    exp_lbl[r * 32 + c] = l;
  endtask

  task automatic build(input int id, input bit c8);
    for (int i = 0; i < NPIX; i++) begin
      img[i] = 1'b0;
      exp_lbl[i] = 0;
    end
    case (id)
      1: begin set_px(0, 0, 1); set_px(1, 1, c8 ? 1 : 2); end
      2: begin
        for (int r = 0; r < 6; r++) begin set_px(r, 2, 1); set_px(r, 6, 1); end
        for (int c = 2; c <= 6; c++) set_px(5, c, 1);
      end
      3: begin
        set_px(1, 8, 2); set_px(1, 9, 2); set_px(2, 8, 2); set_px(2, 9, 2);
        for (int r = 0; r < 5; r++) set_px(r, 5, 1);
        for (int c = 5; c <= 12; c++) set_px(4, c, 1);
      end
      4: for (int r = 0; r < 32; r++)
           for (int c = 0; c < 32; c++)
             if (((r + c) % 2) == 0) set_px(r, c, 1);
      5: begin set_px(0, 1, 1); set_px(1, 0, c8 ? 1 : 2); end
      6: begin set_px(1, 31, 1); set_px(2, 0, 2); end
      default: ;
    endcase
    for (int w = 0; w < 128; w++)
      for (int b = 0; b < 8; b++)
        rom[w][7 - b] = img[w * 8 + b];
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Runs one labeling job, pokes start mid-run and in the done cycle, then scores the writes.
  task automatic run_vec(input int id, input bit c8, input int nlab, input bit ovf);
    int n;
    bit seen;
    build(id, c8);
    clear_mon();
    bus.conn8 = c8;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check($sformatf("busy_rise_%0d", id), int'(bus.busy), 1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < LAT_MAX) begin
      if (n == 300) begin bus.start = 1'b1; bus.conn8 = !c8; end
      if (n == 301) begin bus.start = 1'b0; bus.conn8 = c8; end
      @(posedge clk);
      #1 n++;
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    check($sformatf("done_seen_%0d_%0d", id, c8), int'(seen), 1);
    if (seen) begin
      check($sformatf("num_labels_%0d_%0d", id, c8), int'(bus.num_labels), nlab);
      check($sformatf("overflow_%0d_%0d", id, c8), int'(bus.overflow), int'(ovf));
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      check($sformatf("busy_drop_%0d", id), int'(bus.busy), 0);
      repeat (3) @(posedge clk);
      #1 check($sformatf("done_start_ignored_%0d", id), int'(bus.busy), 0);
    end
    check($sformatf("writes_%0d_%0d", id, c8), wr_cnt, ovf ? 0 : NPIX);
    check($sformatf("addr_order_%0d_%0d", id, c8), addr_err, 0);
    check($sformatf("data_%0d_%0d", id, c8), data_err, 0);
    check($sformatf("done_pulses_%0d_%0d", id, c8), done_cnt, 1);
  endtask

  initial begin
    int n;
    int saved;
    vecs[0]  = '{img: 0, c8: 1'b0, nlab: 0, ovf: 1'b0};
    vecs[1]  = '{img: 1, c8: 1'b0, nlab: 2, ovf: 1'b0};
    vecs[2]  = '{img: 1, c8: 1'b1, nlab: 1, ovf: 1'b0};
    vecs[3]  = '{img: 2, c8: 1'b0, nlab: 1, ovf: 1'b0};
    vecs[4]  = '{img: 3, c8: 1'b0, nlab: 2, ovf: 1'b0};
    vecs[5]  = '{img: 3, c8: 1'b1, nlab: 2, ovf: 1'b0};
    vecs[6]  = '{img: 4, c8: 1'b0, nlab: 0, ovf: 1'b1};
    vecs[7]  = '{img: 4, c8: 1'b1, nlab: 1, ovf: 1'b0};
    vecs[8]  = '{img: 5, c8: 1'b0, nlab: 2, ovf: 1'b0};
    vecs[9]  = '{img: 5, c8: 1'b1, nlab: 1, ovf: 1'b0};
    vecs[10] = '{img: 6, c8: 1'b1, nlab: 2, ovf: 1'b0};
    vecs[11] = '{img: 2, c8: 1'b1, nlab: 1, ovf: 1'b0};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.conn8 = 1'b0;
    build(0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_rom_a", int'(bus.rom_a), 0);
    check("rst_sram_a", int'(bus.sram_a), 0);
    check("rst_sram_d", int'(bus.sram_d), 0);
    check("rst_sram_wen", int'(bus.sram_wen), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_num_labels", int'(bus.num_labels), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 12; v++)
      run_vec(vecs[v].img, vecs[v].c8, vecs[v].nlab, vecs[v].ovf);

    // Abort in the middle of pass 2, then a clean rerun must reproduce the full image.
    build(2, 1'b0);
    clear_mon();
    bus.conn8 = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 0;
    while (wr_cnt < 100 && n < LAT_MAX) begin
      @(posedge clk);
      #1 n++;
    end
    check("mid_pass2_reached", int'(wr_cnt >= 100), 1);
    reset = 1'b1;
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_sram_wen", int'(bus.sram_wen), 1);
    saved = wr_cnt;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_writes", wr_cnt, saved);
    check("abort_stays_idle", int'(bus.busy), 0);
    run_vec(2, 1'b0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
